// File: rtl/regfile_write_arbiter.sv
// Two-source arbiter for the register file write port with a registered output stage.
// Define REGARB_FIXED_PRIO_EN to give the load requester (1) fixed priority; default is round-robin.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_rd,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_rd,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  rWrite,
  output logic [ADDR_WIDTH-1:0] rsWrite,
  output logic [DATA_WIDTH-1:0] dataWrite,
  output logic                  last_grant,
  output logic [CNT_WIDTH-1:0]  conflict_count
);

  logic                  grant0, grant1, both_valid;
  logic                  rwrite_q, rwrite_d;
  logic [ADDR_WIDTH-1:0] rs_q, rs_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  assign both_valid = req0_valid & req1_valid;

  // Readys are gated by reset so requests stay pending until reset releases.
  always_comb begin
`ifdef REGARB_FIXED_PRIO_EN
    grant1 = ~reset & req1_valid;
    grant0 = ~reset & req0_valid & ~req1_valid;
`else
    grant0 = ~reset & req0_valid & (~req1_valid | last_grant_q);
    grant1 = ~reset & req1_valid & (~req0_valid | ~last_grant_q);
`endif
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    rwrite_d     = 1'b0;
    rs_d         = rs_q;
    data_d       = data_q;
    last_grant_d = last_grant_q;
    if (grant0) begin
      rwrite_d     = |req0_rd;
      rs_d         = req0_rd;
      data_d       = req0_data;
      last_grant_d = 1'b0;
    end else if (grant1) begin
      rwrite_d     = |req1_rd;
      rs_d         = req1_rd;
      data_d       = req1_data;
      last_grant_d = 1'b1;
    end
  end

  // Contention counter sticks at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (both_valid && !(&cnt_q)) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rwrite_q     <= 1'b0;
      rs_q         <= '0;
      data_q       <= '0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      rwrite_q     <= rwrite_d;
      rs_q         <= rs_d;
      data_q       <= data_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rWrite         = rwrite_q;
  assign rsWrite        = rs_q;
  assign dataWrite      = data_q;
  assign last_grant     = last_grant_q;
  assign conflict_count = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (CNT_WIDTH = 4 so saturation is reachable).
module tb_regfile_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_rd = '0, req1_rd = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready, rWrite, last_grant;
  logic [AW-1:0] rsWrite;
  logic [DW-1:0] dataWrite;
  logic [CW-1:0] conflict_count;

  int tests_run = 0;
  int tests_failed = 0;

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .rWrite(rWrite), .rsWrite(rsWrite), .dataWrite(dataWrite),
    .last_grant(last_grant), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (rWrite !== 1'b0) begin tests_failed++; $display("FAIL reset_rWrite got %h want 0", rWrite); end
    tests_run++; if (rsWrite !== 5'd0) begin tests_failed++; $display("FAIL reset_rsWrite got %h want 0", rsWrite); end
    tests_run++; if (dataWrite !== 32'd0) begin tests_failed++; $display("FAIL reset_dataWrite got %h want 0", dataWrite); end
    tests_run++; if (last_grant !== 1'b1) begin tests_failed++; $display("FAIL reset_last_grant got %h want 1", last_grant); end
    tests_run++; if (conflict_count !== 4'd0) begin tests_failed++; $display("FAIL reset_count got %h want 0", conflict_count); end
    tests_run++; if ({req0_ready, req1_ready} !== 2'b00) begin tests_failed++; $display("FAIL reset_readys got %b want 00", {req0_ready, req1_ready}); end
  endtask

  task automatic test_single_write();
    apply_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'h0000_00FC;
    #1;
    tests_run++; if ({req0_ready, req1_ready} !== 2'b10) begin tests_failed++; $display("FAIL single_ready got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    tests_run++; if (rWrite !== 1'b1) begin tests_failed++; $display("FAIL single_rWrite got %h want 1", rWrite); end
    tests_run++; if (rsWrite !== 5'd5) begin tests_failed++; $display("FAIL single_rsWrite got %h want 5", rsWrite); end
    tests_run++; if (dataWrite !== 32'hFC) begin tests_failed++; $display("FAIL single_dataWrite got %h want fc", dataWrite); end
    tests_run++; if (last_grant !== 1'b0) begin tests_failed++; $display("FAIL single_last_grant got %h want 0", last_grant); end
    @(negedge clk);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (rWrite !== 1'b0) begin tests_failed++; $display("FAIL single_rWrite_drop got %h want 0", rWrite); end
    tests_run++; if (rsWrite !== 5'd5) begin tests_failed++; $display("FAIL single_rs_hold got %h want 5", rsWrite); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] rds [3];
    rds[0] = 5'd7; rds[1] = 5'd8; rds[2] = 5'd9;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_rd = rds[i]; req0_data = 32'hA000 + i;
      @(posedge clk); #1;
      tests_run++; if ({rWrite, rsWrite} !== {1'b1, rds[i]}) begin tests_failed++; $display("FAIL b2b_write%0d got %b/%h want 1/%h", i, rWrite, rsWrite, rds[i]); end
      tests_run++; if (dataWrite !== 32'hA000 + i) begin tests_failed++; $display("FAIL b2b_data%0d got %h want %h", i, dataWrite, 32'hA000 + i); end
    end
    @(negedge clk);
    req0_valid = 1'b0;
  endtask

  task automatic test_contention();
    logic exp_g;
    apply_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
`ifdef REGARB_FIXED_PRIO_EN
      exp_g = 1'b1;
`else
      exp_g = (i % 2) != 0;
`endif
      #1;
      tests_run++; if ({req0_ready, req1_ready} !== {~exp_g, exp_g}) begin tests_failed++; $display("FAIL cont_ready%0d got %b want %b", i, {req0_ready, req1_ready}, {~exp_g, exp_g}); end
      @(posedge clk); #1;
      tests_run++; if (rsWrite !== (exp_g ? 5'd2 : 5'd1)) begin tests_failed++; $display("FAIL cont_rsWrite%0d got %h want %h", i, rsWrite, exp_g ? 5'd2 : 5'd1); end
      tests_run++; if (dataWrite !== (exp_g ? 32'h22 : 32'h11)) begin tests_failed++; $display("FAIL cont_data%0d got %h want %h", i, dataWrite, exp_g ? 32'h22 : 32'h11); end
      tests_run++; if (last_grant !== exp_g) begin tests_failed++; $display("FAIL cont_last_grant%0d got %h want %h", i, last_grant, exp_g); end
    end
    tests_run++; if (conflict_count !== 4'd4) begin tests_failed++; $display("FAIL cont_count got %0d want 4", conflict_count); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_x0_write();
    apply_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h33;
    @(posedge clk); #1;
    tests_run++; if (last_grant !== 1'b0) begin tests_failed++; $display("FAIL x0_pre_last_grant got %h want 0", last_grant); end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'hDEAD_BEEF;
    #1;
    tests_run++; if ({req0_ready, req1_ready} !== 2'b01) begin tests_failed++; $display("FAIL x0_ready got %b want 01", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    tests_run++; if (rWrite !== 1'b0) begin tests_failed++; $display("FAIL x0_rWrite got %h want 0", rWrite); end
    tests_run++; if (last_grant !== 1'b1) begin tests_failed++; $display("FAIL x0_last_grant got %h want 1", last_grant); end
    tests_run++; if (dataWrite !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL x0_data got %h want deadbeef", dataWrite); end
    @(negedge clk);
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic first_g;
`ifdef REGARB_FIXED_PRIO_EN
    first_g = 1'b1;
`else
    first_g = 1'b0;
`endif
    apply_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 32'h22;
    @(posedge clk); #1;
    tests_run++; if (rWrite !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_rWrite got %h want 1", rWrite); end
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    tests_run++; if (rWrite !== 1'b0) begin tests_failed++; $display("FAIL mid_rWrite got %h want 0", rWrite); end
    tests_run++; if (last_grant !== 1'b1) begin tests_failed++; $display("FAIL mid_last_grant got %h want 1", last_grant); end
    tests_run++; if (conflict_count !== 4'd0) begin tests_failed++; $display("FAIL mid_count got %0d want 0", conflict_count); end
    tests_run++; if ({req0_ready, req1_ready} !== 2'b00) begin tests_failed++; $display("FAIL mid_readys got %b want 00", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    tests_run++; if (rWrite !== 1'b0) begin tests_failed++; $display("FAIL mid_hold_rWrite got %h want 0", rWrite); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++; if ({req0_ready, req1_ready} !== {~first_g, first_g}) begin tests_failed++; $display("FAIL mid_resume_ready got %b want %b", {req0_ready, req1_ready}, {~first_g, first_g}); end
    @(posedge clk); #1;
    tests_run++; if (rsWrite !== (first_g ? 5'd2 : 5'd1)) begin tests_failed++; $display("FAIL mid_resume_rs got %h want %h", rsWrite, first_g ? 5'd2 : 5'd1); end
    @(posedge clk); #1;
    tests_run++; if (rsWrite !== 5'd2) begin tests_failed++; $display("FAIL mid_resume_rs2 got %h want 2", rsWrite); end
    tests_run++; if (conflict_count !== 4'd2) begin tests_failed++; $display("FAIL mid_resume_count got %0d want 2", conflict_count); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_saturation();
    int exp_c;
    apply_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_rd = 5'd4; req0_data = 32'h44;
    req1_valid = 1'b1; req1_rd = 5'd6; req1_data = 32'h66;
    for (int i = 1; i <= 19; i++) begin
      @(posedge clk); #1;
      exp_c = (i > 15) ? 15 : i;
      if (i == 14 || i >= 15) begin
        tests_run++; if (conflict_count !== exp_c[CW-1:0]) begin tests_failed++; $display("FAIL sat_count%0d got %0d want %0d", i, conflict_count, exp_c); end
      end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (conflict_count !== 4'hF) begin tests_failed++; $display("FAIL sat_idle got %0d want 15", conflict_count); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_contention();
    test_x0_write();
    test_reset_midstream();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two writeback sources: requester 0 (ALU result) and requester 1 (memory load result). Each source presents a valid/ready request carrying a destination register index and data. One request is granted per cycle, captured in a registered output stage, and driven onto the register file's write-enable, write-address and write-data inputs on the following cycle. Writes to x0 are accepted but suppressed. The block also reports a saturating count of contention cycles.

## Interface
- DATA_WIDTH, 32, width of write data
- ADDR_WIDTH, 5, width of register index
- CNT_WIDTH, 16, width of contention counter
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has a write pending
- req0_rd  input  ADDR_WIDTH  requester 0 destination register
- req0_data  input  DATA_WIDTH  requester 0 write data
- req0_ready  output  1  requester 0 granted this cycle (combinational)
- req1_valid / req1_rd / req1_data / req1_ready  same as requester 0, for requester 1
- rWrite  output  1  register file write enable (registered)
- rsWrite  output  ADDR_WIDTH  register file write index (registered)
- dataWrite  output  DATA_WIDTH  register file write data (registered)
- last_grant  output  1  id of most recently granted requester
- conflict_count  output  CNT_WIDTH  saturating count of cycles with both valids high

## Operation
- Handshake: a transfer occurs on a rising edge where reqN_valid && reqN_ready. The requester holds valid high with stable rd/data until the transfer completes. Valid never drops without a transfer.
- Grant:
  - Only req0 valid: req0_ready = 1.
  - Only req1 valid: req1_ready = 1.
  - Neither valid: both readys low.
  - Both valid: grant goes to the requester != last_grant (round-robin).
- At most one ready is high per cycle. Ready never asserts without the matching valid.
- On a transfer:
  - rsWrite <= rd.
  - dataWrite <= data.
  - rWrite <= (rd != 0).
  - last_grant <= granted id.
- With no transfer in a cycle, rWrite <= 0. rsWrite and dataWrite hold their previous values.
- x0 filter: a request with rd = 0 completes its handshake normally and updates last_grant, but rWrite stays 0.
- Contention counter:
  - Increments by 1 on every cycle where both valids are high, whether or not a transfer occurs.
  - Saturates at all-ones with no wrap.

## Timing
- Reset values: rWrite = 0, rsWrite = 0, dataWrite = 0, last_grant = 1 (so req0 wins the first conflict), conflict_count = 0.
- reqN_ready depends combinationally on both valids and last_grant. There is no combinational path from rd/data to any output.
- Latency: a transfer at edge T drives rWrite/rsWrite/dataWrite during cycle T..T+1. The register file captures the write at edge T+1.
- Throughput: one write per cycle sustained. Under continuous contention, grants alternate 0,1,0,1.
- Reset mid-operation:
  - All registered outputs clear immediately (asynchronously). An in-flight write in the output stage is lost.
  - While reset is high, both readys are held low, so no transfer occurs.
  - Requesters retain their pending requests and complete them after reset deasserts.
- Simultaneous new request and transfer: a valid rising on the same cycle another requester's request completes is arbitrated in the next cycle against the updated last_grant.

## Configuration
- REGARB_FIXED_PRIO_EN:
  - Defined: requester 1 (load) always wins when both are valid.
  - Undefined: round-robin arbitration as described above.
- In both modes, last_grant still tracks the granted id and conflict_count still counts contention cycles.

## Test plan
- Reset, then idle for 3 cycles: rWrite = 0, rsWrite = 0, dataWrite = 0, last_grant = 1, conflict_count = 0, both readys low.
- Single write: req0_valid with rd = 5, data = 0x0000_00FC for one cycle. Expect req0_ready = 1 that cycle; on the next cycle rWrite = 1, rsWrite = 5, dataWrite = 0xFC; on the cycle after, rWrite = 0.
- Contention: both valid for 4 cycles (req0 rd = 1, data = 0x11; req1 rd = 2, data = 0x22, each held until granted and then re-presented). Expect grant order 0,1,0,1, rsWrite sequence 1,2,1,2, conflict_count = 4. With REGARB_FIXED_PRIO_EN defined, expect grants 1,1,1,1.
- x0 write: req1_valid with rd = 0, data = 0xDEAD_BEEF. Expect req1_ready = 1 and last_grant = 1, but rWrite stays 0.
- Reset mid-stream: assert reset during cycle 2 of the contention scenario. Expect rWrite to drop to 0 immediately, last_grant = 1, conflict_count = 0. After release, req0 is granted first and the sequence resumes.
- Saturation: force both valid for 2^CNT_WIDTH + 3 cycles (use CNT_WIDTH = 4, i.e. 19 cycles). Expect conflict_count to stick at 0xF.
